// File: rtl/irq_pkg.sv
// Shared definitions for the external interrupt requester: line FSM encoding
// and default sizing constants.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    REQ          = 2'd1,
    WAIT_ACK_LOW = 2'd2
  } line_state_t;

  localparam int DEF_NUM_LINES      = 2;
  localparam int DEF_CNT_W          = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/ext_irq_requester_if.sv
// Peripheral-to-core interrupt bus: event/mask inputs, req/ack handshake and
// per-line status. The requester uses the master modport.
interface ext_irq_requester_if #(
  parameter int NUM_LINES = irq_pkg::DEF_NUM_LINES,
  parameter int CNT_W     = irq_pkg::DEF_CNT_W
);

  logic [NUM_LINES-1:0]       event_i;
  logic [NUM_LINES-1:0]       mask_i;
  logic [NUM_LINES-1:0]       irq_req_o;
  logic [NUM_LINES-1:0]       irq_ack_i;
  logic                       clear_status_i;
  logic [NUM_LINES*CNT_W-1:0] pending_o;
  logic [NUM_LINES-1:0]       overflow_o;
  logic [NUM_LINES-1:0]       timeout_o;

  modport master (
    input  event_i, mask_i, irq_ack_i, clear_status_i,
    output irq_req_o, pending_o, overflow_o, timeout_o
  );

  modport slave (
    output event_i, mask_i, irq_ack_i, clear_status_i,
    input  irq_req_o, pending_o, overflow_o, timeout_o
  );

endinterface

// File: rtl/irq_line.sv
// One interrupt line: pending-event counter, four-phase req/ack FSM,
// request timeout watchdog and sticky overflow/timeout flags.
module irq_line
  import irq_pkg::*;
#(
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             evt,
  input  logic             mask,
  input  logic             ack,
  input  logic             clear_status,
  output logic             req,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam int               TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  line_state_t      state_reg, state_next;
  logic             ack_prev_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [TMO_W-1:0] tmo_reg, tmo_next;
  logic             req_reg, req_next;
  logic             overflow_reg, overflow_next;
  logic             timeout_reg, timeout_next;

  logic ack_accept;
  logic count_inc;
  logic overflow_set;
  logic timeout_set;

  always_comb begin
    state_next = state_reg;
    ack_accept = 1'b0;
    case (state_reg)
      IDLE: begin
        if (count_reg != '0 && !mask) state_next = REQ;
      end
      REQ: begin
        // Only a fresh rising edge retires the request; a level held over
        // from an earlier handshake must fall first.
        if (ack && !ack_prev_reg) begin
          ack_accept = 1'b1;
          state_next = WAIT_ACK_LOW;
        end
      end
      WAIT_ACK_LOW: begin
        if (!ack) state_next = (count_reg != '0 && !mask) ? REQ : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_inc    = evt && (count_reg != CNT_MAX || ack_accept);
    overflow_set = evt && count_reg == CNT_MAX && !ack_accept;
    count_next   = count_reg;
    if (count_inc && !ack_accept)
      count_next = count_reg + 1'b1;
    else if (!count_inc && ack_accept && count_reg != '0)
      count_next = count_reg - 1'b1;

    tmo_next = '0;
    if (state_reg == REQ && state_next == REQ)
      tmo_next = (tmo_reg == TMO_LIMIT) ? tmo_reg : tmo_reg + 1'b1;
    timeout_set = (state_reg == REQ) && (tmo_reg == TMO_LIMIT);

    req_next      = (state_next == REQ);
    overflow_next = overflow_set ? 1'b1 : (clear_status ? 1'b0 : overflow_reg);
    timeout_next  = timeout_set  ? 1'b1 : (clear_status ? 1'b0 : timeout_reg);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      ack_prev_reg <= 1'b0;
      count_reg    <= '0;
      tmo_reg      <= '0;
      req_reg      <= 1'b0;
      overflow_reg <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ack_prev_reg <= ack;
      count_reg    <= count_next;
      tmo_reg      <= tmo_next;
      req_reg      <= req_next;
      overflow_reg <= overflow_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign req      = req_reg;
  assign pending  = count_reg;
  assign overflow = overflow_reg;
  assign timeout  = timeout_reg;

endmodule

// File: rtl/ext_irq_requester.sv
// External interrupt requester top: one independent irq_line per core
// interrupt input; this level only slices buses and fans out the clear.
module ext_irq_requester
  import irq_pkg::*;
#(
  parameter int NUM_LINES      = DEF_NUM_LINES,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  ext_irq_requester_if.master bus
);

  logic [NUM_LINES-1:0]       req_w;
  logic [NUM_LINES*CNT_W-1:0] pending_w;
  logic [NUM_LINES-1:0]       overflow_w;
  logic [NUM_LINES-1:0]       timeout_w;

  for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
    irq_line #(
      .CNT_W          (CNT_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_line (
      .clk          (clk),
      .reset        (reset),
      .evt          (bus.event_i[gi]),
      .mask         (bus.mask_i[gi]),
      .ack          (bus.irq_ack_i[gi]),
      .clear_status (bus.clear_status_i),
      .req          (req_w[gi]),
      .pending      (pending_w[gi*CNT_W +: CNT_W]),
      .overflow     (overflow_w[gi]),
      .timeout      (timeout_w[gi])
    );
  end

  assign bus.irq_req_o  = req_w;
  assign bus.pending_o  = pending_w;
  assign bus.overflow_o = overflow_w;
  assign bus.timeout_o  = timeout_w;

endmodule

// File: doc/ext_irq_requester.md
# ext_irq_requester

Peripheral-side initiator of the external interrupt handshake: turns per-line event pulses into held interrupt requests on the core's `External_Interruptrequest` inputs, and retires them against `External_Interruptacknowledge`. Each line queues up to 2^CNT_W−1 outstanding events and runs a four-phase req/ack handshake per event. The block sits at SoC top level between peripherals (timer, GPIO, UART) and the core.

## Interface
- `NUM_LINES`, 2: number of interrupt lines; matches the core request/ack width.
- `CNT_W`, 4: width of each line's pending-event counter.
- `TIMEOUT_CYCLES`, 1024: number of cycles a request may stay unacknowledged before the timeout flag is set.

- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `event_i`  in  NUM_LINES  one-cycle event pulses, one bit per line.
- `mask_i`  in  NUM_LINES  1 = line may not start a new request.
- `irq_req_o`  out  NUM_LINES  request to core `External_Interruptrequest`; registered.
- `irq_ack_i`  in  NUM_LINES  from core `External_Interruptacknowledge`.
- `clear_status_i`  in  1  clears all sticky flags.
- `pending_o`  out  NUM_LINES*CNT_W  per-line pending count; line i occupies bits [i*CNT_W +: CNT_W].
- `overflow_o`  out  NUM_LINES  sticky: an event was dropped because the counter was saturated.
- `timeout_o`  out  NUM_LINES  sticky: a request was held for TIMEOUT_CYCLES cycles.

## Operation
- Reset value of every output is 0. Every counter clears and every FSM goes to IDLE. Reset acts asynchronously, so `irq_req_o` drops immediately, including mid-handshake.
- Lines are fully independent. There is no arbitration between lines; the core's interrupt controller owns priority.
- Pending counter, per line:
  - Event: +1.
  - Ack accepted: −1.
  - Both in the same cycle: net unchanged.
  - Event while count = 2^CNT_W−1: the event is dropped, the count is held, and `overflow_o` is set.
  - Events always count, even while the line is masked.
- FSM per line: IDLE, REQ, WAIT_ACK_LOW.
  - IDLE → REQ when count > 0 and the mask bit is 0.
  - REQ: `irq_req_o` = 1. On a rising edge of ack (ack = 1 and the previous sampled ack = 0), accept the ack, decrement the count, go to WAIT_ACK_LOW.
  - WAIT_ACK_LOW: `irq_req_o` = 0. When ack = 0: go to REQ if count > 0 and unmasked, otherwise go to IDLE.
- Masking while in REQ does not retract the request. A request is never withdrawn before it is acknowledged.
- Ack seen in IDLE is ignored and has no effect.
- Ack already high when REQ is entered is ignored until it falls and rises again.
- Timeout counter:
  - Counts cycles spent in REQ; saturates at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES, sets `timeout_o`; the request stays asserted.
  - Clears on leaving REQ.
- Sticky flags:
  - `clear_status_i` clears all flags.
  - If a set and a clear occur in the same cycle, set wins.
- Arithmetic is unsigned. The pending counter never wraps.

## Timing
- Event pulse sampled at edge k: `pending_o` updates after edge k, and `irq_req_o` is high after edge k+1. Event-to-request latency is 2 cycles.
- Ack rise sampled at edge k: `irq_req_o` is low and the count is decremented after edge k.
- Ack fall sampled at edge m with work remaining: `irq_req_o` is high again after edge m. The minimum request-low gap is 1 cycle.
- `overflow_o` and `timeout_o` are registered and assert 1 cycle after their cause.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `irq_pkg`:
  - FSM state encoding: IDLE = 2'd0, REQ = 2'd1, WAIT_ACK_LOW = 2'd2.
  - Default constants for CNT_W and TIMEOUT_CYCLES.
- Sub-module `irq_line`:
  - Contents: one pending counter, FSM, ack edge register, timeout counter and sticky flags.
  - Instantiated NUM_LINES times by generate.
  - The top level only slices buses and fans out `clear_status_i`.

## Test plan
- Reset release, no stimulus: all outputs 0. Single event on line 0: `pending_o[3:0]` = 1 after 1 cycle; `irq_req_o[0]` = 1 after 2 cycles. Ack pulse on line 0: req drops, pending = 0, FSM back in IDLE.
- Three events on line 1 back-to-back, core acks each with a 2-cycle pulse: exactly 3 request assertions, each separated by ≥1 low cycle; pending goes 3→2→1→0.
- 16 events on line 0 with no ack (CNT_W = 4): pending saturates at 15, `overflow_o[0]` = 1. `clear_status_i` pulse: flag returns to 0.
- Line masked, then 2 events: no request, pending = 2. Unmask: request 1 cycle later. Remask while in REQ: request held until ack.
- Request left unacked for 1024 cycles: `timeout_o` = 1, request still high. Assert `reset` mid-handshake: `irq_req_o` and all flags go to 0 asynchronously.
- Event and ack rise in the same cycle with pending = 1: pending stays 1, and a second request follows after ack falls.
